ldm_stm_sequencer: RTL and testbench

Initiator side of the register-file port pair; executes ARM block transfers (LDM/STM) one register per memory beat.
- Drives register read address / write port toward the register file and a request/ready memory port.
- Sits between decode/execute and the data-memory interface; core stalls while busy.

---
 rtl/armcpu_pkg.sv | 48 ++++
 rtl/lowest_set_bit.sv | 22 ++
 rtl/ldm_stm_sequencer.sv | 175 +++++++++++++++++
 tb/tb_ldm_stm_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/armcpu_pkg.sv
// Shared constants, state/addressing-mode types and helper functions for the
// LDM/STM sequencer.
package armcpu_pkg;

   localparam int WORD_SIZE  = 32;
   localparam int NUM_REGS   = 16;
   localparam int ADDR_WIDTH = 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_XFER,
      S_WB,
      S_DONE
   } state_e;

   // Encoded as {P, U} so the instruction bits can be cast straight in.
   typedef enum logic [1:0] {
      MODE_DA = 2'b00,
      MODE_IA = 2'b01,
      MODE_DB = 2'b10,
      MODE_IB = 2'b11
   } addr_mode_e;

   function automatic logic [ADDR_WIDTH:0] popcount(input logic [NUM_REGS-1:0] mask);
      logic [ADDR_WIDTH:0] n;
      n = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         n = n + {{ADDR_WIDTH{1'b0}}, mask[i]};
      end
      return n;
   endfunction

   // Offset from the base value to the lowest beat address.
   function automatic logic [WORD_SIZE-1:0] start_offset(input addr_mode_e mode,
                                                         input logic [ADDR_WIDTH:0] count);
      logic [WORD_SIZE-1:0] span;
      logic [WORD_SIZE-1:0] offset;
      span = WORD_SIZE'(count) << 2;
      unique case (mode)
         MODE_IA: offset = '0;
         MODE_IB: offset = WORD_SIZE'(32'd4);
         MODE_DA: offset = WORD_SIZE'(32'd4) - span;
         default: offset = '0 - span;
      endcase
      return offset;
   endfunction

endpackage

// File: rtl/lowest_set_bit.sv
// Combinational priority encoder: index of the lowest set bit of a register
// mask, with a valid flag for a non-empty mask.
module lowest_set_bit
   import armcpu_pkg::*;
(
   input  logic [NUM_REGS-1:0]   mask,
   output logic [ADDR_WIDTH-1:0] index,
   output logic                  valid
);

   always_comb begin
      index = '0;
      valid = 1'b0;
      for (int i = NUM_REGS - 1; i >= 0; i--) begin
         if (mask[i]) begin
            index = ADDR_WIDTH'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// ARM LDM/STM block-transfer sequencer: one register per memory beat, optional
// base writeback. Define LDMSTM_ABORT_EN to add the mem_abort/aborted ports.
module ldm_stm_sequencer
   import armcpu_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  is_load,
   input  logic                  pre_index,
   input  logic                  up,
   input  logic                  writeback,
   input  logic [ADDR_WIDTH-1:0] base_reg,
   input  logic [WORD_SIZE-1:0]  base_addr,
   input  logic [NUM_REGS-1:0]   reg_list,
   output logic [ADDR_WIDTH-1:0] rf_read_reg,
   input  logic [WORD_SIZE-1:0]  rf_read_data,
   output logic                  rf_write_en,
   output logic [ADDR_WIDTH-1:0] rf_write_reg,
   output logic [WORD_SIZE-1:0]  rf_write_data,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [WORD_SIZE-1:0]  mem_addr,
   output logic [WORD_SIZE-1:0]  mem_wdata,
   input  logic                  mem_ready,
   input  logic [WORD_SIZE-1:0]  mem_rdata,
   output logic                  busy,
`ifdef LDMSTM_ABORT_EN
   input  logic                  mem_abort,
   output logic                  aborted,
`endif
   output logic                  done
);

   state_e                state_q, state_d;
   logic                  is_load_q, is_load_d;
   logic                  wb_en_q, wb_en_d;
   logic [ADDR_WIDTH-1:0] base_reg_q, base_reg_d;
   logic [WORD_SIZE-1:0]  final_base_q, final_base_d;
   logic [WORD_SIZE-1:0]  addr_q, addr_d;
   logic [NUM_REGS-1:0]   mask_q, mask_d;
   logic [ADDR_WIDTH-1:0] cur_idx;
   logic                  cur_valid;
   logic [ADDR_WIDTH:0]   count;
   logic [WORD_SIZE-1:0]  span;
   logic                  beat_abort;

`ifdef LDMSTM_ABORT_EN
   logic aborted_q, aborted_d;
   assign beat_abort = mem_abort;
   assign aborted    = (state_q == S_DONE) && aborted_q;
`else
   assign beat_abort = 1'b0;
`endif

   lowest_set_bit u_lsb (
      .mask  (mask_q),
      .index (cur_idx),
      .valid (cur_valid)
   );

   assign count = popcount(reg_list);
   assign span  = WORD_SIZE'(count) << 2;
   assign busy  = (state_q != S_IDLE);

   always_comb begin
      state_d       = state_q;
      is_load_d     = is_load_q;
      wb_en_d       = wb_en_q;
      base_reg_d    = base_reg_q;
      final_base_d  = final_base_q;
      addr_d        = addr_q;
      mask_d        = mask_q;
`ifdef LDMSTM_ABORT_EN
      aborted_d     = aborted_q;
`endif
      rf_read_reg   = '0;
      rf_write_en   = 1'b0;
      rf_write_reg  = '0;
      rf_write_data = '0;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      mem_addr      = '0;
      mem_wdata     = '0;
      done          = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               is_load_d    = is_load;
               // A load that includes the base register keeps the loaded value.
               wb_en_d      = writeback && !(is_load && reg_list[base_reg]);
               base_reg_d   = base_reg;
               mask_d       = reg_list;
               addr_d       = base_addr + start_offset(addr_mode_e'({pre_index, up}), count);
               final_base_d = up ? (base_addr + span) : (base_addr - span);
`ifdef LDMSTM_ABORT_EN
               aborted_d    = 1'b0;
`endif
               state_d      = (count == '0) ? S_DONE : S_XFER;
            end
         end

         S_XFER: begin
            mem_req  = cur_valid;
            mem_addr = addr_q;
            mem_we   = !is_load_q;
            if (!is_load_q) begin
               rf_read_reg = cur_idx;
               mem_wdata   = rf_read_data;
            end
            if (mem_ready) begin
               if (beat_abort) begin
`ifdef LDMSTM_ABORT_EN
                  aborted_d = 1'b1;
`endif
                  state_d   = S_DONE;
               end else begin
                  if (is_load_q) begin
                     rf_write_en   = 1'b1;
                     rf_write_reg  = cur_idx;
                     rf_write_data = mem_rdata;
                  end
                  mask_d = mask_q & ~(NUM_REGS'(1) << cur_idx);
                  addr_d = addr_q + WORD_SIZE'(32'd4);
                  if (mask_d == '0) begin
                     state_d = wb_en_q ? S_WB : S_DONE;
                  end
               end
            end
         end

         S_WB: begin
            rf_write_en   = 1'b1;
            rf_write_reg  = base_reg_q;
            rf_write_data = final_base_q;
            state_d       = S_DONE;
         end

         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         is_load_q    <= 1'b0;
         wb_en_q      <= 1'b0;
         base_reg_q   <= '0;
         final_base_q <= '0;
         addr_q       <= '0;
         mask_q       <= '0;
`ifdef LDMSTM_ABORT_EN
         aborted_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         is_load_q    <= is_load_d;
         wb_en_q      <= wb_en_d;
         base_reg_q   <= base_reg_d;
         final_base_q <= final_base_d;
         addr_q       <= addr_d;
         mask_q       <= mask_d;
`ifdef LDMSTM_ABORT_EN
         aborted_q    <= aborted_d;
`endif
      end
   end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Self-checking bench for ldm_stm_sequencer: directed and randomized block
// transfers compared beat by beat against an expected-transfer model.
module tb_ldm_stm_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        is_load;
   logic        pre_index;
   logic        up;
   logic        writeback;
   logic [3:0]  base_reg;
   logic [31:0] base_addr;
   logic [15:0] reg_list;
   logic [3:0]  rf_read_reg;
   logic [31:0] rf_read_data;
   logic        rf_write_en;
   logic [3:0]  rf_write_reg;
   logic [31:0] rf_write_data;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        busy;
   logic        done;
`ifdef LDMSTM_ABORT_EN
   logic        mem_abort;
   logic        aborted;
`endif

   logic [31:0] rf_model [16];
   int          total  = 0;
   int          passed = 0;

   always #5 clk = ~clk;

   assign rf_read_data = rf_model[rf_read_reg];

   ldm_stm_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .is_load       (is_load),
      .pre_index     (pre_index),
      .up            (up),
      .writeback     (writeback),
      .base_reg      (base_reg),
      .base_addr     (base_addr),
      .reg_list      (reg_list),
      .rf_read_reg   (rf_read_reg),
      .rf_read_data  (rf_read_data),
      .rf_write_en   (rf_write_en),
      .rf_write_reg  (rf_write_reg),
      .rf_write_data (rf_write_data),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_ready     (mem_ready),
      .mem_rdata     (mem_rdata),
      .busy          (busy),
`ifdef LDMSTM_ABORT_EN
      .mem_abort     (mem_abort),
      .aborted       (aborted),
`endif
      .done          (done)
   );

   // Runs one transfer: the expected beat list is the set registers in
   // ascending order at consecutive words from the mode's lowest address.
   task automatic run_xfer(input logic ld, input logic p, input logic u, input logic w,
                           input logic [3:0] breg, input logic [31:0] base,
                           input logic [15:0] list, input int ready_pct,
                           input int abort_beat, input bit scramble);
      int          regs[$];
      int          cnt;
      int          beat;
      int          cyc;
      bit          exp_wb;
      bit          fin_seen;
      bit          wb_seen;
      bit          ab_seen;
      bit          abort_now;
      logic [31:0] addr0;
      logic [31:0] fin;
      regs = {};
      for (int i = 0; i < 16; i++) if (list[i]) regs.push_back(i);
      cnt = regs.size();
      case ({p, u})
         2'b01:   addr0 = base;
         2'b11:   addr0 = base + 32'd4;
         2'b00:   addr0 = base - 32'(4 * cnt) + 32'd4;
         default: addr0 = base - 32'(4 * cnt);
      endcase
      fin    = u ? base + 32'(4 * cnt) : base - 32'(4 * cnt);
      exp_wb = w && !(ld && list[breg]) && (cnt != 0);
      rf_model[breg] = base;

      start = 1'b1; is_load = ld; pre_index = p; up = u; writeback = w;
      base_reg = breg; base_addr = base; reg_list = list; mem_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      beat = 0; cyc = 1; fin_seen = 0; wb_seen = 0; ab_seen = 0;
      while (!fin_seen && cyc < 300) begin
         mem_ready = ($urandom_range(1, 100) <= ready_pct);
         mem_rdata = $urandom;
         abort_now = mem_ready && (beat == abort_beat);
`ifdef LDMSTM_ABORT_EN
         mem_abort = abort_now;
`else
         abort_now = 1'b0;
`endif
         if (scramble) begin
            start = 1'($urandom); is_load = 1'($urandom); pre_index = 1'($urandom);
            up = 1'($urandom); writeback = 1'($urandom); base_reg = 4'($urandom);
            base_addr = $urandom; reg_list = 16'($urandom);
         end
         #1;
         total++;
         if (busy !== 1'b1) $display("[TB] FAIL busy_active: got %b want 1 (cycle %0d)", busy, cyc);
         else passed++;
         if (mem_req) begin
            total++;
            if (beat >= cnt || ab_seen || wb_seen)
               $display("[TB] FAIL extra_beat: got beat %0d want at most %0d beats", beat, cnt);
            else if ({mem_we, mem_addr} !== {!ld, addr0 + 32'(4 * beat)})
               $display("[TB] FAIL beat_addr: got we=%b addr=%h want we=%b addr=%h",
                        mem_we, mem_addr, !ld, addr0 + 32'(4 * beat));
            else if (!ld && mem_wdata !== rf_model[regs[beat]])
               $display("[TB] FAIL store_data: got %h want %h (r%0d)", mem_wdata, rf_model[regs[beat]], regs[beat]);
            else if ({rf_write_en, done} !== {ld && mem_ready && !abort_now, 1'b0})
               $display("[TB] FAIL beat_wen: got wen=%b done=%b want wen=%b done=0",
                        rf_write_en, done, ld && mem_ready && !abort_now);
            else if (rf_write_en && {rf_write_reg, rf_write_data} !== {4'(regs[beat]), mem_rdata})
               $display("[TB] FAIL load_write: got r%0d=%h want r%0d=%h",
                        rf_write_reg, rf_write_data, regs[beat], mem_rdata);
            else passed++;
            if (mem_ready && beat < cnt) begin
               if (abort_now) ab_seen = 1;
               else begin
                  if (ld) rf_model[regs[beat]] = mem_rdata;
                  beat++;
               end
            end
         end else if (rf_write_en) begin
            total++;
            if (!exp_wb || wb_seen || ab_seen || beat != cnt)
               $display("[TB] FAIL unexpected_write: got r%0d=%h want no write", rf_write_reg, rf_write_data);
            else if ({rf_write_reg, rf_write_data, done} !== {breg, fin, 1'b0})
               $display("[TB] FAIL wb_value: got r%0d=%h done=%b want r%0d=%h done=0",
                        rf_write_reg, rf_write_data, done, breg, fin);
            else passed++;
            wb_seen = 1;
            rf_model[rf_write_reg] = rf_write_data;
         end else if (done) begin
            fin_seen = 1;
            total++;
            if (beat != (ab_seen ? abort_beat : cnt) || wb_seen != (exp_wb && !ab_seen))
               $display("[TB] FAIL done_state: got beats=%0d wb=%b want beats=%0d wb=%b",
                        beat, wb_seen, ab_seen ? abort_beat : cnt, exp_wb && !ab_seen);
            else passed++;
            if (ready_pct >= 100 && abort_beat < 0) begin
               total++;
               if (cyc != cnt + int'(exp_wb) + 1)
                  $display("[TB] FAIL done_latency: got %0d want %0d", cyc, cnt + int'(exp_wb) + 1);
               else passed++;
            end
`ifdef LDMSTM_ABORT_EN
            total++;
            if (aborted !== 1'(ab_seen)) $display("[TB] FAIL aborted_flag: got %b want %b", aborted, ab_seen);
            else passed++;
`endif
         end else begin
            total++;
            $display("[TB] FAIL stray_cycle: got busy with no req/write/done want activity (cycle %0d)", cyc);
         end
         if (!fin_seen) begin
            @(negedge clk);
            cyc++;
         end
      end
      if (!fin_seen) begin
         total++;
         $display("[TB] FAIL timeout: got no done after %0d cycles want done", cyc);
      end
      start = 1'b0; mem_ready = 1'b0;
`ifdef LDMSTM_ABORT_EN
      mem_abort = 1'b0;
`endif
      @(negedge clk);
      #1;
      total++;
      if ({busy, done, mem_req, rf_write_en} !== 4'b0000)
         $display("[TB] FAIL idle_after_done: got busy=%b done=%b req=%b wen=%b want all 0",
                  busy, done, mem_req, rf_write_en);
      else passed++;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
      is_load = 1'b0; pre_index = 1'b0; up = 1'b0; writeback = 1'b0;
      base_reg = '0; base_addr = '0; reg_list = '0;
`ifdef LDMSTM_ABORT_EN
      mem_abort = 1'b0;
`endif
      repeat (3) @(negedge clk);
      #1;
      total++;
      if ({busy, done, mem_req, mem_we, rf_write_en, mem_addr, mem_wdata,
           rf_write_reg, rf_write_data, rf_read_reg} !== '0)
         $display("[TB] FAIL reset_outputs: got busy=%b done=%b req=%b addr=%h want all 0",
                  busy, done, mem_req, mem_addr);
      else passed++;
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_directed();
      run_xfer(1'b0, 1'b0, 1'b1, 1'b1, 4'd5,  32'h0000_1000, 16'h000B, 100, -1, 1'b0);
      run_xfer(1'b1, 1'b1, 1'b0, 1'b1, 4'd13, 32'h0000_2000, 16'h8001, 100, -1, 1'b0);
      run_xfer(1'b1, 1'b0, 1'b1, 1'b1, 4'd2,  32'h0000_3000, 16'h0004, 100, -1, 1'b0);
      run_xfer(1'b0, 1'b1, 1'b1, 1'b1, 4'd3,  32'h0000_4000, 16'h0000, 100, -1, 1'b0);
      run_xfer(1'b0, 1'b0, 1'b0, 1'b1, 4'd9,  32'h0000_0008, 16'h0212, 100, -1, 1'b0);
   endtask

   task automatic test_stall();
      run_xfer(1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 32'h0000_6000, 16'h0F0F, 30, -1, 1'b0);
      run_xfer(1'b1, 1'b1, 1'b0, 1'b0, 4'd7, 32'h0000_7000, 16'hA5A5, 25, -1, 1'b1);
   endtask

   task automatic test_reset_mid();
      start = 1'b1; is_load = 1'b1; pre_index = 1'b0; up = 1'b1; writeback = 1'b1;
      base_reg = 4'd1; base_addr = 32'h0000_5000; reg_list = 16'h00F0; mem_ready = 1'b0;
      @(negedge clk);
      start = 1'b0; mem_ready = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      #1;
      total++;
      if ({busy, done, mem_req, rf_write_en, mem_addr, rf_write_data} !== '0)
         $display("[TB] FAIL reset_mid_outputs: got busy=%b req=%b wen=%b addr=%h want all 0",
                  busy, mem_req, rf_write_en, mem_addr);
      else passed++;
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         #1;
         total++;
         if ({busy, done, mem_req, rf_write_en} !== 4'b0000)
            $display("[TB] FAIL reset_mid_quiet: got busy=%b done=%b req=%b wen=%b want all 0",
                     busy, done, mem_req, rf_write_en);
         else passed++;
      end
      mem_ready = 1'b0;
   endtask

   task automatic test_random();
      for (int n = 0; n < 20; n++) begin
         run_xfer(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom_range(0, 15)),
                  $urandom & 32'hFFFF_FFFC, 16'($urandom), int'($urandom_range(40, 100)), -1, 1'b1);
      end
   endtask

   task automatic test_back_to_back();
      run_xfer(1'b0, 1'b0, 1'b1, 1'b1, 4'd4, 32'h0000_8000, 16'h0003, 100, -1, 1'b0);
      run_xfer(1'b1, 1'b0, 1'b1, 1'b1, 4'd4, 32'h0000_8000, 16'h0003, 100, -1, 1'b0);
      run_xfer(1'b1, 1'b1, 1'b1, 1'b1, 4'd8, 32'hFFFF_FFF8, 16'h0101, 100, -1, 1'b0);
      run_xfer(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 32'h0000_0004, 16'h0006, 100, -1, 1'b0);
   endtask

`ifdef LDMSTM_ABORT_EN
   task automatic test_abort();
      run_xfer(1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 32'h0000_9000, 16'h00F0, 100, 1, 1'b0);
      run_xfer(1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 32'h0000_A000, 16'h0F00, 50, 2, 1'b0);
   endtask
`endif

   initial begin
      for (int i = 0; i < 16; i++) rf_model[i] = $urandom;
      test_reset();
      test_directed();
      test_stall();
      test_reset_mid();
      test_random();
      test_back_to_back();
`ifdef LDMSTM_ABORT_EN
      test_abort();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
